// File: rtl/q_meter_pkg.sv
// Shared types for the resonator Q meter.
package q_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXCITE,
    WAIT_HI,
    COUNT,
    DONE
  } q_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/q_meter_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses.
module sync_edge
  import q_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   q_d;

  assign q = sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      q_d  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], d};
      q_d  <= q;
      rise <= q & ~q_d;
      fall <= ~q & q_d;
    end
  end

endmodule

// File: rtl/q_meter.sv
// Resonator Q meter: excite, wait for env_hi fall, count osc edges to env_lo fall.
// Optional Q_METER_AVG_EN averages 2**AVG_LOG2 passes per request.
module q_meter
  import q_meter_pkg::*;
#(
  parameter int BUS_WIDTH   = 10,
  parameter int TIMER_W     = 16,
  parameter int EXCITE_CYC  = 64,
  parameter int TIMEOUT_CYC = 4095,
  parameter int AVG_LOG2    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 osc_in,
  input  logic                 env_hi,
  input  logic                 env_lo,
  output logic                 excite,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready,
  output logic                 busy,
  output logic                 timeout
);

  localparam logic [TIMER_W-1:0] EX_LAST = TIMER_W'(EXCITE_CYC - 1);
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [BUS_WIDTH-1:0] CNT_MAX = '1;

  q_state_t             state;
  logic [TIMER_W-1:0]   timer;
  logic [BUS_WIDTH-1:0] cnt;
  logic [BUS_WIDTH-1:0] cnt_nx;

  logic osc_q, osc_rise, osc_fall;
  logic hi_q, hi_rise, hi_fall;
  logic lo_q, lo_rise, lo_fall;

  sync_edge u_osc (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (osc_in),
    .q    (osc_q),
    .rise (osc_rise),
    .fall (osc_fall)
  );

  sync_edge u_hi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (env_hi),
    .q    (hi_q),
    .rise (hi_rise),
    .fall (hi_fall)
  );

  sync_edge u_lo (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (env_lo),
    .q    (lo_q),
    .rise (lo_rise),
    .fall (lo_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{osc_q, osc_fall, hi_q, hi_rise, lo_q, lo_rise};

  // An osc edge coincident with the closing env_lo edge still counts.
  always_comb begin
    cnt_nx = cnt;
    if (osc_rise && cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
  end

`ifdef Q_METER_AVG_EN
  localparam int ACC_W = BUS_WIDTH + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] PASS_LAST = '1;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum_nx;
  logic [AVG_LOG2-1:0] pass;

  assign sum_nx = acc + ACC_W'(cnt_nx);
`else
  logic unused_avg;
  assign unused_avg = 1'(AVG_LOG2);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      cnt        <= '0;
      excite     <= 1'b0;
      q_measured <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
`ifdef Q_METER_AVG_EN
      acc        <= '0;
      pass       <= '0;
`endif
    end else if (start) begin
      state   <= EXCITE;
      timer   <= '0;
      cnt     <= '0;
      excite  <= 1'b1;
      ready   <= 1'b0;
      busy    <= 1'b1;
      timeout <= 1'b0;
`ifdef Q_METER_AVG_EN
      acc     <= '0;
      pass    <= '0;
`endif
    end else begin
      unique case (state)
        EXCITE: begin
          if (timer == EX_LAST) begin
            excite <= 1'b0;
            timer  <= '0;
            state  <= WAIT_HI;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_HI: begin
          if (hi_fall) begin
            cnt   <= '0;
            timer <= '0;
            state <= COUNT;
          end else if (timer == TO_LAST) begin
            state      <= DONE;
            timeout    <= 1'b1;
            q_measured <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COUNT: begin
          if (lo_fall) begin
`ifdef Q_METER_AVG_EN
            if (pass == PASS_LAST) begin
              state      <= DONE;
              q_measured <= sum_nx[ACC_W-1:AVG_LOG2];
              ready      <= 1'b1;
              busy       <= 1'b0;
            end else begin
              acc    <= sum_nx;
              pass   <= pass + 1'b1;
              timer  <= '0;
              excite <= 1'b1;
              state  <= EXCITE;
            end
`else
            state      <= DONE;
            q_measured <= cnt_nx;
            ready      <= 1'b1;
            busy       <= 1'b0;
`endif
          end else if (timer == TO_LAST) begin
            state      <= DONE;
            timeout    <= 1'b1;
            q_measured <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt   <= cnt_nx;
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
